fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch controller at the front of the 16-bit processor pipeline, on the consumer side of the stall interface. It owns the program counter, addresses program memory, and loads the instruction register. It exports the opcode field to the stall block and obeys that block's `stall` / `stall_pm` replies by freezing the PC and injecting NOP bubbles. It also handles branch redirects and a terminal HALT state.

## Interface
- `PC_W`, 16: program-counter / program-memory address width.
- `IW`, 32: instruction width; opcode is `ir[IW-1:IW-6]`.
- `RESET_PC`, 0: PC value after reset.
- `NOP`, 0: bubble instruction word (opcode 6'b000000).
- `HALT_OP`, 6'b111111: opcode that halts fetch.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `stall` in 1: from the stall block; load a bubble into `ir` this cycle.
- `stall_pm` in 1: from the stall block; hold the PC (program memory re-reads the same address).
- `redirect` in 1: branch/jump taken; flush and load a new PC.
- `redirect_pc` in PC_W: target address.
- `pm_data` in IW: program-memory read data for `pm_addr`; combinational, same cycle.
- `pm_addr` out PC_W: equals the `pc` register.
- `ir` out IW: instruction register.
- `op` out 6: `ir[IW-1:IW-6]`; goes to the stall block's `op`.
- `ir_valid` out 1: `ir` holds a fetched instruction, not a bubble.
- `halted` out 1: FSM is in HALT.
- `bubble_cnt` out 16: count of bubble cycles; saturates at 16'hFFFF.

## Operation
FSM states: BOOT, RUN, HALT.

- **Reset (asynchronous)**
  - `pc`=RESET_PC, `ir`=NOP, `ir_valid`=0, `halted`=0, `bubble_cnt`=0.
  - State = BOOT, so `op`=0.
- **BOOT**
  - Lasts exactly one cycle after reset deassertion.
  - `ir` <= NOP. PC holds. Goes to RUN.
  - The bubble is not counted.
- **RUN, `pc` update, first matching rule wins:**
  1. `redirect` → `pc` <= `redirect_pc`.
  2. `stall_pm` → `pc` holds.
  3. Otherwise `pc` <= `pc`+1, modulo 2^PC_W (16'hFFFF wraps to 0).
- **RUN, `ir` update, first matching rule wins:**
  1. `redirect` or `stall` → `ir` <= NOP, `ir_valid` <= 0, `bubble_cnt`++ (saturating).
  2. Otherwise `ir` <= `pm_data`, `ir_valid` <= 1.
- **Independence:** `stall` and `stall_pm` act independently.
  - `stall` alone: the PC advances and the instruction at the old `pc` is dropped. The stall block only does this on control ops.
  - `stall_pm` alone: `ir` reloads the same word.
- **HALT entry:** when `ir_valid`=1 and `op`==HALT_OP, the next state is HALT.
  - The halting instruction is still presented for that one cycle.
  - A `redirect` in that same cycle is ignored.
- **HALT:**
  - `pc` frozen, `ir` <= NOP, `ir_valid`=0, `halted`=1.
  - `bubble_cnt` frozen.
  - All inputs ignored; exit only via reset.
- **Fixed widths:** PC and counter arithmetic are fixed-width, with no sign extension. `redirect_pc` is taken verbatim.

## Timing
- All state is registered on the `clk` rising edge. `pm_addr`, `op`, and `halted` are direct register decodes with no input-to-output combinational path.
- Fetch latency is 1 cycle: the address presented in cycle N appears in `ir`/`op` in cycle N+1.
- The stall block samples `op` and returns `stall`/`stall_pm`, which this block samples at the next edge.
- The stall inputs must be stable before the edge. Pulses narrower than a cycle are ignored by design.
- Redirect penalty: exactly 1 bubble. `ir`=NOP in cycle N+1; the target instruction arrives in cycle N+2.
- Reset asserted mid-operation clears immediately and asynchronously. On release, BOOT runs again: the first real fetch from RESET_PC lands in `ir` two edges after release.

## Structure
- Shared package `cpu_pkg`:
  - opcode width (6) and opcode constants `OP_NOP`, `OP_HALT`;
  - `NOP` word;
  - fetch FSM state encoding (BOOT/RUN/HALT, 2-bit).
- Sub-module `sat_counter16` (enable, async active-low reset, saturating at all-ones) for `bubble_cnt`.
- Everything else (PC register, IR register, FSM) lives in `fetch_ctrl`.

## Test plan
- **Reset/boot:** `reset`=0 for 6 ns, then 1 → `pm_addr`=0, `ir`=0, `ir_valid`=0 for one cycle; `ir`=`pm_data`@0 at the second edge; `pm_addr` steps 1, 2, 3.
- **`stall_pm` hold:** `stall_pm`=1 for 3 cycles at `pc`=5 → `pm_addr` stays 5 for 3 cycles, `ir` reloads word@5 each cycle, then `pc`=6 follows.
- **Stall bubbles:** `op`=6'b010100 makes the stall model drive `stall`=1 for 2 cycles → `ir`=NOP twice, `ir_valid`=0, `bubble_cnt` 0→2, `op` seen by the stall block is 0 during the bubbles.
- **Redirect priority:** `redirect`=1, `redirect_pc`=16'h0040, with `stall_pm`=1 in the same cycle → `pm_addr`=16'h0040 next cycle, one NOP, then word@0x40 in `ir`.
- **Wrap and halt:** run from `pc`=16'hFFFE → 16'hFFFF → 16'h0000. Place 6'b111111 at 0 → `halted`=1 one cycle after HALT enters `ir`; `pm_addr` frozen; a `redirect` pulse during HALT has no effect.
- **Async reset mid-run:** pulse `reset` low between edges while `bubble_cnt`=7 and `pc`=16'h0123 → all outputs clear before the next edge, `bubble_cnt`=0, BOOT repeats.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared constants and types for the 16-bit processor front end:       |
// | opcode field width, well-known opcodes, the bubble word and the      |
// | fetch FSM state encoding.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  // Bubble instruction: an all-zero word decodes as OP_NOP.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter16                                                        |
// | 16-bit up-counter with enable that sticks at all-ones.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  // Count enabled cycles; once all-ones is reached the value holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl                                                           |
// | Instruction-fetch controller: owns the PC, addresses program memory, |
// | loads the instruction register, obeys stall/stall_pm from the stall  |
// | block, handles branch redirects and a terminal HALT state.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                PC_W     = 16,
  parameter int                IW       = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [IW-1:0]     NOP      = IW'(NOP_WORD),
  parameter logic [OP_W-1:0]   HALT_OP  = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              stall_pm,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic [IW-1:0]     pm_data,
  output logic [PC_W-1:0]   pm_addr,
  output logic [IW-1:0]     ir,
  output logic [OP_W-1:0]   op,
  output logic              ir_valid,
  output logic              halted,
  output logic [15:0]       bubble_cnt
);

  fetch_state_e        r_state;
  logic [PC_W-1:0]     r_pc;
  logic [IW-1:0]       r_ir;
  logic                r_ir_valid;

  logic                w_halt_now;
  logic                w_bubble;

  // A valid HALT sitting in the IR wins over everything else this cycle,
  // including a redirect, so the halting edge neither moves the PC nor
  // counts a bubble.
  assign w_halt_now = (r_state == ST_RUN) && r_ir_valid &&
                      (r_ir[IW-1 -: OP_W] == HALT_OP);

  // Only ordinary RUN cycles that squash the fetch are counted; the BOOT
  // bubble and the HALT-entry bubble are not.
  assign w_bubble = (r_state == ST_RUN) && !w_halt_now && (redirect || stall);

  // Fetch FSM: PC, IR and valid flag all advance together on one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_ir       <= NOP;
      r_ir_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_ir       <= NOP;
          r_ir_valid <= 1'b0;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (w_halt_now) begin
            r_ir       <= NOP;
            r_ir_valid <= 1'b0;
            r_state    <= ST_HALT;
          end else begin
            if (redirect) begin
              r_pc <= redirect_pc;
            end else if (!stall_pm) begin
              r_pc <= r_pc + PC_W'(1);
            end
            if (redirect || stall) begin
              r_ir       <= NOP;
              r_ir_valid <= 1'b0;
            end else begin
              r_ir       <= pm_data;
              r_ir_valid <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          r_ir       <= NOP;
          r_ir_valid <= 1'b0;
        end
        default: begin
          r_ir       <= NOP;
          r_ir_valid <= 1'b0;
          r_state    <= ST_BOOT;
        end
      endcase
    end
  end

  sat_counter16 u_bubble_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_bubble),
    .o_count (bubble_cnt)
  );

  assign pm_addr  = r_pc;
  assign ir       = r_ir;
  assign op       = r_ir[IW-1 -: OP_W];
  assign ir_valid = r_ir_valid;
  assign halted   = (r_state == ST_HALT);

endmodule
`default_nettype wire
